washer_ctrl_gen2: RTL and testbench

- Second-generation washing-machine sequencer with internal cycle timers, so it no longer depends on external time-out strobes.
- Configurable rinse count, pause/resume, abort-with-drain, and watchdog faults on fill and drain.
- Sits between the front-panel/sensor inputs and the valve, motor and lock actuator drivers.

---
 rtl/washer_ctrl_gen2.sv | 198 +++++++++++++++++++
 tb/tb_washer_ctrl_gen2.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_ctrl_gen2.sv
// washer_ctrl_gen2 -- washing-machine program sequencer with internal phase
// timers, rinse counting, pause/resume, abort-with-drain and fill/drain
// watchdogs.
//
// Ports
//   clk, rst (async, active low)
//   start, door_closed, filled, drained, pause, abort, fault_clr : panel/sensors
//   door_lock, fill_valve, drain_valve, motor_on, motor_fast, dose : actuators
//   done        : one-cycle end-of-program pulse
//   fault       : fault indicator, err_code gives the cause
//                 (01 fill timeout, 10 drain timeout, 11 door opened)
//   state       : current state (debug)
//   rinse_idx   : rinses completed in the current program
//
// All outputs are decoded from registered state only.
module washer_ctrl_gen2 #(
  parameter int CNT_W         = 16,
  parameter int WASH_CYCLES   = 64,
  parameter int RINSE_CYCLES  = 32,
  parameter int RINSE_COUNT   = 2,
  parameter int SPIN_CYCLES   = 48,
  parameter int FILL_TIMEOUT  = 200,
  parameter int DRAIN_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       door_closed,
  input  logic       filled,
  input  logic       drained,
  input  logic       pause,
  input  logic       abort,
  input  logic       fault_clr,
  output logic       door_lock,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       dose,
  output logic       done,
  output logic       fault,
  output logic [1:0] err_code,
  output logic [3:0] state,
  output logic [2:0] rinse_idx
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FILL    = 4'd1;
  localparam logic [3:0] S_DOSE    = 4'd2;
  localparam logic [3:0] S_AGITATE = 4'd3;
  localparam logic [3:0] S_DRAIN   = 4'd4;
  localparam logic [3:0] S_SPIN    = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd6;
  localparam logic [3:0] S_FAULT   = 4'd7;
  localparam logic [3:0] S_PAUSED  = 4'd8;

  // Terminal timer values: a phase of N cycles ends when the timer shows N-1.
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]       RC4        = 4'(RINSE_COUNT);

  logic [3:0]       state_q, state_d;
  logic [3:0]       saved_q, saved_d;
  logic [CNT_W-1:0] timer_q, timer_d, timer_inc;
  logic             phase_q, phase_d;   // 0 = WASH, 1 = RINSE
  logic [2:0]       ri_q, ri_d;
  logic             abort_q, abort_d;
  logic [1:0]       err_q, err_d;

  logic lock, abortable, pausable, abort_eff, pausing, resuming;

  assign lock      = (state_q inside {S_FILL, S_DOSE, S_AGITATE, S_DRAIN, S_SPIN, S_PAUSED});
  assign abortable = (state_q inside {S_FILL, S_DOSE, S_AGITATE, S_SPIN, S_PAUSED});
  assign pausable  = (state_q inside {S_FILL, S_AGITATE, S_DRAIN, S_SPIN});
  // An abort arriving while already draining only latches the flag; the
  // drain step itself still proceeds and sees the flag this same cycle.
  assign abort_eff = abort_q | (abort & (state_q == S_DRAIN));
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    phase_d  = phase_q;
    ri_d     = ri_q;
    abort_d  = abort_q;
    err_d    = err_q;
    pausing  = 1'b0;
    resuming = 1'b0;
    if (lock && !door_closed) begin
      state_d = S_FAULT;
      err_d   = 2'b11;
      abort_d = 1'b0;
    end else if (abort && abortable) begin
      state_d = S_DRAIN;
      abort_d = 1'b1;
    end else begin
      abort_d = abort_eff;
      if (pause && pausable) begin
        state_d = S_PAUSED;
        saved_d = state_q;
        pausing = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (start && door_closed) begin
            state_d = S_FILL;
            phase_d = 1'b0;
            ri_d    = 3'd0;
          end
          S_FILL: begin
            if (filled) state_d = phase_q ? S_AGITATE : S_DOSE;
            else if (timer_q == FILL_LAST) begin
              state_d = S_FAULT;
              err_d   = 2'b01;
              abort_d = 1'b0;
            end
          end
          S_DOSE: state_d = S_AGITATE;
          S_AGITATE: if (timer_q == (phase_q ? RINSE_LAST : WASH_LAST)) state_d = S_DRAIN;
          S_DRAIN: begin
            if (drained) begin
              if (abort_eff) begin
                state_d = S_IDLE;
                abort_d = 1'b0;
              end else if (!phase_q && RC4 != 4'd0) begin
                state_d = S_FILL;
                phase_d = 1'b1;
              end else if (phase_q && (({1'b0, ri_q} + 4'd1) < RC4)) begin
                state_d = S_FILL;
                ri_d    = ri_q + 3'd1;
              end else begin
                state_d = S_SPIN;
                if (phase_q) ri_d = ri_q + 3'd1;
              end
            end else if (timer_q == DRAIN_LAST) begin
              state_d = S_FAULT;
              err_d   = 2'b10;
              abort_d = 1'b0;
            end
          end
          S_SPIN: if (timer_q == SPIN_LAST) state_d = S_DONE;
          S_DONE: state_d = S_IDLE;
          S_FAULT: if (fault_clr) begin
            state_d = S_IDLE;
            err_d   = 2'b00;
          end
          S_PAUSED: if (!pause) begin
            state_d  = saved_q;
            resuming = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // The cycle on which pause is taken still counts toward the phase; the
    // count then holds through PAUSED and carries back on resume.
    if (pausing)                   timer_d = timer_inc;
    else if (state_q == S_PAUSED)  timer_d = (resuming || state_d == S_PAUSED) ? timer_q : '0;
    else if (state_d == state_q)   timer_d = timer_inc;
    else                           timer_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      timer_q <= '0;
      phase_q <= 1'b0;
      ri_q    <= 3'd0;
      abort_q <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
      ri_q    <= ri_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign door_lock   = lock;
  assign fill_valve  = (state_q == S_FILL);
  assign drain_valve = (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign motor_on    = (state_q == S_AGITATE) || (state_q == S_SPIN);
  assign motor_fast  = (state_q == S_SPIN);
  assign dose        = (state_q == S_DOSE);
  assign done        = (state_q == S_DONE);
  assign fault       = (state_q == S_FAULT);
  assign err_code    = err_q;
  assign state       = state_q;
  assign rinse_idx   = ri_q;

endmodule

// File: tb/tb_washer_ctrl_gen2.sv
// Bench for washer_ctrl_gen2: two instances (RINSE_COUNT 2 and 0) share the
// stimulus; a program-level reference model predicts every output each cycle,
// and directed program runs pin the model with hand-derived sequences.
module tb_washer_ctrl_gen2;
  localparam int WC = 8, RCY = 4, SC = 4, FT = 16, DT = 16;

  logic clk, rst, start, door_closed, filled, drained, pause, abort, fault_clr;
  logic dl0, fv0, dv0, mo0, mf0, ds0, dn0, ft0;
  logic dl1, fv1, dv1, mo1, mf1, ds1, dn1, ft1;
  logic [1:0] ec0, ec1;
  logic [3:0] st0, st1;
  logic [2:0] ri0, ri1;

  washer_ctrl_gen2 #(.CNT_W(16), .WASH_CYCLES(WC), .RINSE_CYCLES(RCY), .RINSE_COUNT(2),
    .SPIN_CYCLES(SC), .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT)) u0 (
    .clk(clk), .rst(rst), .start(start), .door_closed(door_closed), .filled(filled),
    .drained(drained), .pause(pause), .abort(abort), .fault_clr(fault_clr),
    .door_lock(dl0), .fill_valve(fv0), .drain_valve(dv0), .motor_on(mo0), .motor_fast(mf0),
    .dose(ds0), .done(dn0), .fault(ft0), .err_code(ec0), .state(st0), .rinse_idx(ri0));

  washer_ctrl_gen2 #(.CNT_W(16), .WASH_CYCLES(WC), .RINSE_CYCLES(RCY), .RINSE_COUNT(0),
    .SPIN_CYCLES(SC), .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT)) u1 (
    .clk(clk), .rst(rst), .start(start), .door_closed(door_closed), .filled(filled),
    .drained(drained), .pause(pause), .abort(abort), .fault_clr(fault_clr),
    .door_lock(dl1), .fill_valve(fv1), .drain_valve(dv1), .motor_on(mo1), .motor_fast(mf1),
    .dose(ds1), .done(dn1), .fault(ft1), .err_code(ec1), .state(st1), .rinse_idx(ri1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Program-level model. el = active (non-paused) cycles spent in the
  // current step so far; ab = abort requested, finish with drain then idle.
  typedef struct {
    int st; int el; int sv; bit rinse; int ri; bit ab; int err;
  } mst_t;

  function automatic mst_t mstep(mst_t m, int rc, bit go, bit door, bit full, bit empty,
                                 bit hold, bit cancel, bit clr);
    mst_t n = m;
    bit locked = m.st inside {1, 2, 3, 4, 5, 8};
    bit took_pause = 0, resumed = 0, ab;
    if (locked && !door) begin
      n.st = 7; n.err = 3; n.ab = 0;
    end else if (cancel && (m.st inside {1, 2, 3, 5, 8})) begin
      n.st = 4; n.ab = 1;
    end else begin
      ab = m.ab | (cancel && m.st == 4);
      n.ab = ab;
      if (hold && (m.st inside {1, 3, 4, 5})) begin
        n.st = 8; n.sv = m.st; took_pause = 1;
      end else begin
        case (m.st)
          0: if (go && door) begin n.st = 1; n.rinse = 0; n.ri = 0; end
          1: if (full) n.st = m.rinse ? 3 : 2;
             else if (m.el == FT - 1) begin n.st = 7; n.err = 1; n.ab = 0; end
          2: n.st = 3;
          3: if (m.el == (m.rinse ? RCY : WC) - 1) n.st = 4;
          4: if (empty) begin
               if (ab) begin n.st = 0; n.ab = 0; end
               else if (!m.rinse && rc > 0) begin n.st = 1; n.rinse = 1; end
               else if (m.rinse && m.ri + 1 < rc) begin n.st = 1; n.ri = m.ri + 1; end
               else begin n.st = 5; if (m.rinse) n.ri = m.ri + 1; end
             end else if (m.el == DT - 1) begin n.st = 7; n.err = 2; n.ab = 0; end
          5: if (m.el == SC - 1) n.st = 6;
          6: n.st = 0;
          7: if (clr) begin n.st = 0; n.err = 0; end
          8: if (!hold) begin n.st = m.sv; resumed = 1; end
          default: n.st = 0;
        endcase
      end
    end
    if (took_pause) n.el = m.el + 1;
    else if (m.st == 8) n.el = (resumed || n.st == 8) ? m.el : 0;
    else if (n.st == m.st) n.el = m.el + 1;
    else n.el = 0;
    return n;
  endfunction

  function automatic logic [16:0] expo(mst_t m);
    logic lk = m.st inside {1, 2, 3, 4, 5, 8};
    return {lk, m.st == 1, m.st == 4 || m.st == 5, m.st == 3 || m.st == 5, m.st == 5,
            m.st == 2, m.st == 6, m.st == 7, 2'(m.err), 4'(m.st), 3'(m.ri)};
  endfunction

  mst_t m0, m1;
  int p1 = 0, d2s = 0, d2f = 0;

  // Compare process: outputs checked mid-cycle; inputs seen here are the ones
  // the DUT samples at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m0 = '{default: 0};
        m1 = '{default: 0};
      end
      chk("u0_outputs", 32'({dl0, fv0, dv0, mo0, mf0, ds0, dn0, ft0, ec0, st0, ri0}), 32'(expo(m0)));
      chk("u1_outputs", 32'({dl1, fv1, dv1, mo1, mf1, ds1, dn1, ft1, ec1, st1, ri1}), 32'(expo(m1)));
      if (p1 == 4 && st1 == 4'd5) d2s++;
      if (p1 == 4 && st1 == 4'd1) d2f++;
      p1 = int'(st1);
      if (rst) begin
        m0 = mstep(m0, 2, start, door_closed, filled, drained, pause, abort, fault_clr);
        m1 = mstep(m1, 0, start, door_closed, filled, drained, pause, abort, fault_clr);
      end
    end
  end

  int seq[$], lens[$];
  int dones, doses;
  bit mo_pause;

  task automatic step();
    @(posedge clk);
    #2;
    if (seq.size() == 0 || int'(st0) != seq[seq.size()-1]) begin
      seq.push_back(int'(st0));
      lens.push_back(1);
    end else lens[lens.size()-1] = lens[lens.size()-1] + 1;
    if (dn0) dones++;
    if (ds0) doses++;
    if (st0 == 4'd8 && mo0) mo_pause = 1;
  endtask

  // mode: 0 normal, 1 never filled, 2 pause in wash agitate, 3 abort in spin,
  // 4 door opened with abort during first drain
  task automatic run_prog(input int mode);
    bit pdone = 0, fin = 0;
    seq.delete(); lens.delete();
    dones = 0; doses = 0; mo_pause = 0;
    start = 1; step(); start = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      filled  = (mode != 1) && st0 == 4'd1 && lens[lens.size()-1] >= 3;
      drained = st0 == 4'd4 && lens[lens.size()-1] >= 3;
      if (mode == 2 && !pdone && st0 == 4'd3 && lens[lens.size()-1] == 3) begin
        pause = 1; repeat (10) step(); pause = 0; pdone = 1;
        filled = 0; drained = 0;
      end
      if (mode == 3 && st0 == 4'd5 && lens[lens.size()-1] == 2) abort = 1;
      if (mode == 4 && st0 == 4'd4 && lens[lens.size()-1] == 2) begin door_closed = 0; abort = 1; end
      step();
      if (mode != 4) abort = 0;
      if (st0 == 4'd0 || st0 == 4'd7) fin = 1;
    end
    filled = 0; drained = 0;
    chk("prog_finished", 32'(fin), 32'd1);
  endtask

  int e1[13] = '{1, 2, 3, 4, 1, 3, 4, 1, 3, 4, 5, 6, 0};

  initial begin
    rst = 0; start = 0; door_closed = 1; filled = 0; drained = 0;
    pause = 0; abort = 0; fault_clr = 0;
    step(); step();
    chk("reset_outputs", 32'({dl0, fv0, dv0, mo0, mf0, ds0, dn0, ft0, ec0, st0, ri0}), 32'd0);
    rst = 1;
    step();

    // Full program; the RINSE_COUNT=0 instance must go drain -> spin once.
    d2s = 0; d2f = 0;
    run_prog(0);
    chk("full_seq_len", 32'(seq.size()), 32'd13);
    if (seq.size() == 13) begin
      for (int i = 0; i < 13; i++) chk("full_seq", 32'(seq[i]), 32'(e1[i]));
      chk("wash_agitate_len", 32'(lens[2]), 32'd8);
      chk("rinse1_len", 32'(lens[5]), 32'd4);
      chk("rinse2_len", 32'(lens[8]), 32'd4);
      chk("spin_len", 32'(lens[10]), 32'd4);
    end
    chk("dose_cycles", 32'(doses), 32'd1);
    chk("done_cycles", 32'(dones), 32'd1);
    chk("rinse_idx_end", 32'(ri0), 32'd2);
    chk("rc0_drain_to_spin", 32'(d2s), 32'd1);
    chk("rc0_drain_to_fill", 32'(d2f), 32'd0);
    repeat (10) step();

    // Fill watchdog.
    run_prog(1);
    chk("fill_to_fault", 32'(lens[0]), 32'd16);
    chk("fill_fault_outs", 32'({ft0, ec0, fv0, dl0}), 32'b1_01_0_0);
    fault_clr = 1; step(); fault_clr = 0;
    chk("fault_clr", 32'({st0, ec0}), 32'd0);
    step();

    // Pause three cycles into wash agitate.
    run_prog(2);
    if (seq.size() >= 6) begin
      chk("pre_pause_len", 32'(lens[2]), 32'd3);
      chk("paused_state", 32'(seq[3]), 32'd8);
      chk("paused_len", 32'(lens[3]), 32'd10);
      chk("resume_len", 32'(lens[4]), 32'd5);
    end else chk("pause_seq_len", 32'(seq.size()), 32'd6);
    chk("motor_in_pause", 32'(mo_pause), 32'd0);
    chk("pause_done", 32'(dones), 32'd1);
    step();

    // Abort in spin.
    run_prog(3);
    chk("abort_done", 32'(dones), 32'd0);
    if (seq.size() >= 3) begin
      chk("abort_from_spin", 32'(seq[seq.size()-3]), 32'd5);
      chk("abort_drain", 32'(seq[seq.size()-2]), 32'd4);
      chk("abort_idle", 32'(seq[seq.size()-1]), 32'd0);
    end
    step();

    // Door opened in drain while abort also asserted.
    run_prog(4);
    chk("door_fault", 32'({st0, ec0, dl0}), 32'({4'd7, 2'b11, 1'b0}));
    door_closed = 1; abort = 0;
    fault_clr = 1; step(); fault_clr = 0;
    step();

    // Asynchronous reset in the middle of FILL.
    start = 1; step(); start = 0; step();
    chk("mid_fill", 32'(st0), 32'd1);
    #1 rst = 0;
    #1;
    chk("async_rst", 32'({fv0, dl0, st0}), 32'd0);
    step();
    rst = 1;
    step();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 2500; i++) begin
      start       = ($urandom_range(3) == 0);
      door_closed = ($urandom_range(99) >= 2);
      filled      = ($urandom_range(2) == 0);
      drained     = ($urandom_range(2) == 0);
      pause       = ($urandom_range(9) == 0);
      abort       = ($urandom_range(39) == 0);
      fault_clr   = ($urandom_range(7) == 0);
      step();
    end
    start = 0; pause = 0; abort = 0; door_closed = 1;
    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
